// File: rtl/oddr_tx_serializer_pkg.sv
// Shared types and sizing helpers for the ODDR transmit gearbox.
package oddr_tx_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

    // One DDR pair as presented to ODDR.D1/D2 (d1 is the earlier bit on the line).
    typedef struct packed {
        logic d1;
        logic d2;
    } ser_pair_t;

    localparam int unsigned PAIR_W = 2;

    function automatic int unsigned ser_np(input int unsigned width);
        return width / PAIR_W;
    endfunction

    // Pair counter width; never narrower than one bit so WIDTH=2 still has a counter.
    function automatic int unsigned ser_cnt_w(input int unsigned np);
        return (np > 1) ? unsigned'($clog2(np)) : 1;
    endfunction

    function automatic bit ser_width_ok(input int unsigned width);
        return (width >= PAIR_W) && ((width % PAIR_W) == 0);
    endfunction

endpackage

// File: rtl/oddr_tx_serializer_if.sv
// Parallel word handshake into the gearbox.
interface oddr_tx_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready_c;

    modport master (
        output din,
        output din_valid,
        input  din_ready_c
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready_c
    );
endinterface

// File: rtl/oddr_tx_serializer.sv
// Parallel-to-DDR gearbox feeding an ODDR in SAME_EDGE mode: two line bits per clock,
// gapless back-to-back words, IDLE level between words.
module oddr_tx_serializer
    import oddr_tx_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter logic        IDLE      = 1'b0,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                 c_i,
    input  logic                 r_i,
    input  logic                 ce_i,
    oddr_tx_serializer_if.slave  in_if,
    output logic                 d1_o,
    output logic                 d2_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int unsigned NP = ser_np(WIDTH);
    localparam int unsigned CW = ser_cnt_w(NP);
    localparam logic [CW-1:0] CNT_LAST  = CW'(NP - 1);
    localparam ser_pair_t     IDLE_PAIR = ser_pair_t'({IDLE, IDLE});

    if (!ser_width_ok(WIDTH)) begin : g_bad_width
        $error("oddr_tx_serializer: WIDTH must be even and >= 2");
    end

    ser_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sh_q;
    ser_pair_t        pair_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] word_ord_c;
    logic [WIDTH-1:0] load_sh_d;
    logic [WIDTH-1:0] next_sh_d;
    ser_pair_t        load_pair_d;
    ser_pair_t        next_pair_d;
    logic             last_pair_c;
    logic             accept_c;

    // Put the word in line order so the earliest bit always sits at the top.
    always_comb begin
        word_ord_c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            word_ord_c[WIDTH-1-i] = MSB_FIRST ? in_if.din[WIDTH-1-i] : in_if.din[i];
        end
    end

    always_comb begin
        load_pair_d = ser_pair_t'(word_ord_c[WIDTH-1 -: PAIR_W]);
        load_sh_d   = word_ord_c << PAIR_W;
        next_pair_d = ser_pair_t'(sh_q[WIDTH-1 -: PAIR_W]);
        next_sh_d   = sh_q << PAIR_W;
    end

    assign last_pair_c       = (cnt_q == CNT_LAST);
    assign in_if.din_ready_c = ce_i & ~r_i & ((state_q == ST_IDLE) | last_pair_c);
    assign accept_c          = in_if.din_valid & in_if.din_ready_c;

    // Control and datapath; a disabled cycle freezes everything except the DONE pulse.
    always_ff @(posedge c_i) begin
        if (r_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            pair_q  <= IDLE_PAIR;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (!ce_i) begin
            done_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        pair_q  <= load_pair_d;
                        sh_q    <= load_sh_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end else begin
                        pair_q  <= IDLE_PAIR;
                    end
                end
                ST_SHIFT: begin
                    if (!last_pair_c) begin
                        pair_q  <= next_pair_d;
                        sh_q    <= next_sh_d;
                        cnt_q   <= cnt_q + CW'(1);
                    end else if (accept_c) begin
                        // Chain straight into the next word without an idle bubble.
                        pair_q  <= load_pair_d;
                        sh_q    <= load_sh_d;
                        cnt_q   <= '0;
                    end else begin
                        pair_q  <= IDLE_PAIR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign d1_o   = pair_q.d1;
    assign d2_o   = pair_q.d2;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_oddr_tx_serializer.sv
// Scoreboard bench for oddr_tx_serializer: MSB-first and LSB-first 8-bit instances share
// stimulus; a 2-bit instance with IDLE=1 runs beside them.
module tb_oddr_tx_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic r;
    logic ce;

    oddr_tx_serializer_if #(.WIDTH(8)) if_m ();
    oddr_tx_serializer_if #(.WIDTH(8)) if_l ();
    oddr_tx_serializer_if #(.WIDTH(2)) if_w ();

    logic m_d1, m_d2, m_busy, m_done;
    logic l_d1, l_d2, l_busy, l_done;
    logic w_d1, w_d2, w_busy, w_done;

    oddr_tx_serializer #(.WIDTH(8), .IDLE(1'b0), .MSB_FIRST(1'b1)) u_m (
        .c_i(clk), .r_i(r), .ce_i(ce), .in_if(if_m),
        .d1_o(m_d1), .d2_o(m_d2), .busy_o(m_busy), .done_o(m_done));

    oddr_tx_serializer #(.WIDTH(8), .IDLE(1'b0), .MSB_FIRST(1'b0)) u_l (
        .c_i(clk), .r_i(r), .ce_i(ce), .in_if(if_l),
        .d1_o(l_d1), .d2_o(l_d2), .busy_o(l_busy), .done_o(l_done));

    oddr_tx_serializer #(.WIDTH(2), .IDLE(1'b1), .MSB_FIRST(1'b1)) u_w (
        .c_i(clk), .r_i(r), .ce_i(ce), .in_if(if_w),
        .d1_o(w_d1), .d2_o(w_d2), .busy_o(w_busy), .done_o(w_done));

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard: pending line pairs per instance plus expected visible outputs.
    logic [1:0] q_m[$];
    logic [1:0] q_l[$];
    logic [1:0] q_w[$];
    logic [1:0] e_m, e_l, e_w;
    logic       eb_m, eb_l, eb_w;
    logic       ed_m, ed_l, ed_w;
    logic       er_m, er_l, er_w;
    logic       or_m, or_l, or_w;

    function automatic logic [1:0] pair_of(input logic [7:0] w, input int width, input bit msb, input int k);
        if (msb) return {w[width-1-2*k], w[width-2-2*k]};
        return {w[2*k], w[2*k+1]};
    endfunction

    // One clock: drive inputs, sample ready, push accepted words, advance the line model.
    task automatic tick(input logic v8, input logic [7:0] w8, input logic v2, input logic [1:0] w2);
        logic [7:0] w2x;
        w2x = {6'b0, w2};
        if_m.din = w8; if_m.din_valid = v8;
        if_l.din = w8; if_l.din_valid = v8;
        if_w.din = w2; if_w.din_valid = v2;
        #1;
        er_m = ce && !r && (q_m.size() == 0);
        er_l = ce && !r && (q_l.size() == 0);
        er_w = ce && !r && (q_w.size() == 0);
        or_m = if_m.din_ready_c;
        or_l = if_l.din_ready_c;
        or_w = if_w.din_ready_c;
        if (v8 && er_m) for (int k = 0; k < 4; k++) q_m.push_back(pair_of(w8, 8, 1'b1, k));
        if (v8 && er_l) for (int k = 0; k < 4; k++) q_l.push_back(pair_of(w8, 8, 1'b0, k));
        if (v2 && er_w) q_w.push_back(pair_of(w2x, 2, 1'b1, 0));
        @(posedge clk);
        #1;
        if (r) begin
            q_m.delete(); q_l.delete(); q_w.delete();
            e_m = 2'b00; e_l = 2'b00; e_w = 2'b11;
            eb_m = 0; eb_l = 0; eb_w = 0;
            ed_m = 0; ed_l = 0; ed_w = 0;
        end else if (ce) begin
            ed_m = eb_m && (q_m.size() == 0);
            ed_l = eb_l && (q_l.size() == 0);
            ed_w = eb_w && (q_w.size() == 0);
            if (q_m.size() > 0) begin e_m = q_m.pop_front(); eb_m = 1; end else begin e_m = 2'b00; eb_m = 0; end
            if (q_l.size() > 0) begin e_l = q_l.pop_front(); eb_l = 1; end else begin e_l = 2'b00; eb_l = 0; end
            if (q_w.size() > 0) begin e_w = q_w.pop_front(); eb_w = 1; end else begin e_w = 2'b11; eb_w = 0; end
        end else begin
            ed_m = 0; ed_l = 0; ed_w = 0;
        end
    endtask

    task automatic test_reset();
        r = 1'b1; ce = 1'b1;
        tick(1'b0, 8'h00, 1'b0, 2'b00);
        tick(1'b1, 8'hFF, 1'b1, 2'b00);
        n_vec += 7;
        if (or_m !== 1'b0) begin n_err++; $display("FAIL reset_ready_m got %b want 0", or_m); end
        if (or_w !== 1'b0) begin n_err++; $display("FAIL reset_ready_w got %b want 0", or_w); end
        if ({m_d1, m_d2} !== 2'b00) begin n_err++; $display("FAIL reset_pair_m got %b want 00", {m_d1, m_d2}); end
        if ({l_d1, l_d2} !== 2'b00) begin n_err++; $display("FAIL reset_pair_l got %b want 00", {l_d1, l_d2}); end
        if ({w_d1, w_d2} !== 2'b11) begin n_err++; $display("FAIL reset_pair_w got %b want 11", {w_d1, w_d2}); end
        if ({m_busy, m_done} !== 2'b00) begin n_err++; $display("FAIL reset_flags_m got %b want 00", {m_busy, m_done}); end
        if ({w_busy, w_done} !== 2'b00) begin n_err++; $display("FAIL reset_flags_w got %b want 00", {w_busy, w_done}); end
        r = 1'b0;
    endtask

    task automatic test_single_msb();
        for (int i = 0; i < 7; i++) begin
            tick(i == 0, 8'hB4, 1'b0, 2'b00);
            n_vec += 4;
            if (or_m !== er_m) begin n_err++; $display("FAIL single_msb ready cyc%0d got %b want %b", i, or_m, er_m); end
            if ({m_d1, m_d2} !== e_m) begin n_err++; $display("FAIL single_msb pair cyc%0d got %b want %b", i + 1, {m_d1, m_d2}, e_m); end
            if (m_busy !== eb_m) begin n_err++; $display("FAIL single_msb busy cyc%0d got %b want %b", i + 1, m_busy, eb_m); end
            if (m_done !== ed_m) begin n_err++; $display("FAIL single_msb done cyc%0d got %b want %b", i + 1, m_done, ed_m); end
        end
    endtask

    task automatic test_single_lsb();
        for (int i = 0; i < 7; i++) begin
            tick(i == 0, 8'hB4, 1'b0, 2'b00);
            n_vec += 4;
            if (or_l !== er_l) begin n_err++; $display("FAIL single_lsb ready cyc%0d got %b want %b", i, or_l, er_l); end
            if ({l_d1, l_d2} !== e_l) begin n_err++; $display("FAIL single_lsb pair cyc%0d got %b want %b", i + 1, {l_d1, l_d2}, e_l); end
            if (l_busy !== eb_l) begin n_err++; $display("FAIL single_lsb busy cyc%0d got %b want %b", i + 1, l_busy, eb_l); end
            if (l_done !== ed_l) begin n_err++; $display("FAIL single_lsb done cyc%0d got %b want %b", i + 1, l_done, ed_l); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        for (int i = 0; i < 11; i++) begin
            w = (i < 4) ? 8'hFF : 8'h00;
            tick(i < 5, w, 1'b0, 2'b00);
            n_vec += 8;
            if (or_m !== er_m) begin n_err++; $display("FAIL b2b ready_m cyc%0d got %b want %b", i, or_m, er_m); end
            if (or_l !== er_l) begin n_err++; $display("FAIL b2b ready_l cyc%0d got %b want %b", i, or_l, er_l); end
            if ({m_d1, m_d2} !== e_m) begin n_err++; $display("FAIL b2b pair_m cyc%0d got %b want %b", i + 1, {m_d1, m_d2}, e_m); end
            if ({l_d1, l_d2} !== e_l) begin n_err++; $display("FAIL b2b pair_l cyc%0d got %b want %b", i + 1, {l_d1, l_d2}, e_l); end
            if (m_busy !== eb_m) begin n_err++; $display("FAIL b2b busy_m cyc%0d got %b want %b", i + 1, m_busy, eb_m); end
            if (l_busy !== eb_l) begin n_err++; $display("FAIL b2b busy_l cyc%0d got %b want %b", i + 1, l_busy, eb_l); end
            if (m_done !== ed_m) begin n_err++; $display("FAIL b2b done_m cyc%0d got %b want %b", i + 1, m_done, ed_m); end
            if (l_done !== ed_l) begin n_err++; $display("FAIL b2b done_l cyc%0d got %b want %b", i + 1, l_done, ed_l); end
        end
    endtask

    task automatic test_ce_toggle();
        logic       v;
        logic [7:0] w;
        for (int i = 0; i < 18; i++) begin
            ce = (i == 0) || (i >= 11) || (i % 2 == 0);
            v  = (i == 0) || (i == 10) || (i == 11);
            w  = (i == 0) ? 8'h1B : 8'h3C;
            tick(v, w, 1'b0, 2'b00);
            n_vec += 4;
            if (or_m !== er_m) begin n_err++; $display("FAIL ce_toggle ready cyc%0d got %b want %b", i, or_m, er_m); end
            if ({m_d1, m_d2} !== e_m) begin n_err++; $display("FAIL ce_toggle pair cyc%0d got %b want %b", i + 1, {m_d1, m_d2}, e_m); end
            if (m_busy !== eb_m) begin n_err++; $display("FAIL ce_toggle busy cyc%0d got %b want %b", i + 1, m_busy, eb_m); end
            if (m_done !== ed_m) begin n_err++; $display("FAIL ce_toggle done cyc%0d got %b want %b", i + 1, m_done, ed_m); end
        end
        ce = 1'b1;
    endtask

    task automatic test_mid_reset();
        logic [7:0] w;
        for (int i = 0; i < 11; i++) begin
            r = (i == 3);
            w = (i == 0) ? 8'hA5 : 8'h96;
            tick((i == 0) || (i == 4), w, 1'b0, 2'b00);
            n_vec += 4;
            if (or_m !== er_m) begin n_err++; $display("FAIL mid_reset ready cyc%0d got %b want %b", i, or_m, er_m); end
            if ({m_d1, m_d2} !== e_m) begin n_err++; $display("FAIL mid_reset pair cyc%0d got %b want %b", i + 1, {m_d1, m_d2}, e_m); end
            if (m_busy !== eb_m) begin n_err++; $display("FAIL mid_reset busy cyc%0d got %b want %b", i + 1, m_busy, eb_m); end
            if (m_done !== ed_m) begin n_err++; $display("FAIL mid_reset done cyc%0d got %b want %b", i + 1, m_done, ed_m); end
        end
        r = 1'b0;
    endtask

    task automatic test_w2_idle_high();
        logic [1:0] w;
        for (int i = 0; i < 5; i++) begin
            w = (i == 1) ? 2'b01 : 2'b10;
            tick(1'b0, 8'h00, (i == 1) || (i == 2), w);
            n_vec += 4;
            if (or_w !== er_w) begin n_err++; $display("FAIL w2 ready cyc%0d got %b want %b", i, or_w, er_w); end
            if ({w_d1, w_d2} !== e_w) begin n_err++; $display("FAIL w2 pair cyc%0d got %b want %b", i + 1, {w_d1, w_d2}, e_w); end
            if (w_busy !== eb_w) begin n_err++; $display("FAIL w2 busy cyc%0d got %b want %b", i + 1, w_busy, eb_w); end
            if (w_done !== ed_w) begin n_err++; $display("FAIL w2 done cyc%0d got %b want %b", i + 1, w_done, ed_w); end
        end
    endtask

    initial begin
        r = 1'b1;
        ce = 1'b1;
        test_reset();
        test_single_msb();
        test_single_lsb();
        test_back_to_back();
        test_ce_toggle();
        test_mid_reset();
        test_w2_idle_high();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
